target_extend_pipe: RTL

TARGET_EXTEND_PIPE -- requirements
Module: target_extend_pipe

---
 rtl/tgt_pkg.sv | 16 +
 rtl/tgt_extend.sv | 31 +++
 rtl/target_extend_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tgt_pkg.sv
// Shared types and default widths for the branch/jump target extender.
// Holds the 2-bit mode enum and the default IN_W/OUT_W/SHIFT constants.
package tgt_pkg;

   localparam int TGT_IN_W  = 26;
   localparam int TGT_OUT_W = 32;
   localparam int TGT_SHIFT = 2;

   typedef enum logic [1:0] {
      TGT_ZEXT   = 2'd0,
      TGT_SEXT   = 2'd1,
      TGT_JUMP   = 2'd2,
      TGT_BRANCH = 2'd3
   } tgt_mode_e;

endpackage

// File: rtl/tgt_extend.sv
// Combinational first-stage operand former: zero/sign extension plus shift.
// Ports: mode (tgt_mode_e), imm [IN_W-1:0] -> operand [OUT_W-1:0].
module tgt_extend
   import tgt_pkg::*;
#(
   parameter int IN_W  = TGT_IN_W,
   parameter int OUT_W = TGT_OUT_W,
   parameter int SHIFT = TGT_SHIFT
) (
   input  tgt_mode_e        mode,
   input  logic [IN_W-1:0]  imm,
   output logic [OUT_W-1:0] operand
);

   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;

   assign zext = {{(OUT_W-IN_W){1'b0}}, imm};
   assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      operand = '0;
      unique case (mode)
         TGT_ZEXT:   operand = zext;
         TGT_SEXT:   operand = sext;
         TGT_JUMP:   operand = zext << SHIFT;
         TGT_BRANCH: operand = sext << SHIFT;
      endcase
   end

endmodule

// File: rtl/target_extend_pipe.sv
// Two-stage valid/ready pipeline computing extended immediates and jump/branch
// targets. Macro TGT_BRANCH_EN builds the branch adder; without it mode 3
// returns target=0, err=1.
// Ports: clk, rst_n (async low); in_valid/in_ready, mode, imm, pc4 (request);
// flush (drop in-flight); out_valid/out_ready, target, err (result).
module target_extend_pipe
   import tgt_pkg::*;
#(
   parameter int IN_W  = TGT_IN_W,
   parameter int OUT_W = TGT_OUT_W,
   parameter int SHIFT = TGT_SHIFT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [IN_W-1:0]  imm,
   input  logic [OUT_W-1:0] pc4,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] target,
   output logic             err
);

   localparam int HI_W = OUT_W - IN_W - SHIFT;

   logic             v1;
   logic             v2;
   logic             load1;
   logic             load2;
   tgt_mode_e        mode1;
   logic [OUT_W-1:0] op1;
   logic [OUT_W-1:0] op_nxt;
   logic [OUT_W-1:0] tgt_nxt;
   logic             err_nxt;

`ifdef TGT_BRANCH_EN
   logic [OUT_W-1:0] pc1;
   logic             carry;
`else
   // Only the page bits of pc4 matter when no branch adder exists.
   logic [HI_W-1:0]  pc1;
   logic             unused_pc;
   assign unused_pc = ^pc4[IN_W+SHIFT-1:0];
`endif

   assign load2     = !v2 || out_ready;
   assign load1     = !v1 || load2;
   assign in_ready  = load1;
   assign out_valid = v2;

   tgt_extend #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SHIFT (SHIFT)
   ) u_ext (
      .mode    (tgt_mode_e'(mode)),
      .imm     (imm),
      .operand (op_nxt)
   );

   // Stage 1: operand, mode, pc4.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         mode1 <= TGT_ZEXT;
         op1   <= '0;
         pc1   <= '0;
      end else begin
         if (flush) begin
            v1 <= 1'b0;
         end else if (load1) begin
            v1 <= in_valid;
         end
         if (load1 && in_valid) begin
            mode1 <= tgt_mode_e'(mode);
            op1   <= op_nxt;
`ifdef TGT_BRANCH_EN
            pc1   <= pc4;
`else
            pc1   <= pc4[OUT_W-1:IN_W+SHIFT];
`endif
         end
      end
   end

   // Stage 2 result. Branch overflow: a carry out of the unsigned add
   // disagrees with the offset sign exactly when the PC wrapped.
   always_comb begin
      tgt_nxt = '0;
      err_nxt = 1'b0;
`ifdef TGT_BRANCH_EN
      carry   = 1'b0;
`endif
      unique case (mode1)
         TGT_ZEXT,
         TGT_SEXT: tgt_nxt = op1;
         TGT_JUMP: begin
`ifdef TGT_BRANCH_EN
            tgt_nxt = {pc1[OUT_W-1:IN_W+SHIFT], op1[IN_W+SHIFT-1:0]};
`else
            tgt_nxt = {pc1, op1[IN_W+SHIFT-1:0]};
`endif
         end
         TGT_BRANCH: begin
`ifdef TGT_BRANCH_EN
            {carry, tgt_nxt} = {1'b0, pc1} + {1'b0, op1};
            err_nxt = carry ^ op1[OUT_W-1];
`else
            tgt_nxt = '0;
            err_nxt = 1'b1;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2     <= 1'b0;
         target <= '0;
         err    <= 1'b0;
      end else begin
         if (flush) begin
            v2 <= 1'b0;
         end else if (load2) begin
            v2 <= v1;
         end
         if (load2 && v1) begin
            target <= tgt_nxt;
            err    <= err_nxt;
         end
      end
   end

endmodule
